// File: rtl/cmu_param.sv
// Cache management unit: drives a direct-mapped write-back cache, does write-back/fill on miss, flushes lines on request.
// Latency: hits complete the same cycle; a miss costs one line transfer per memory phase plus one WAIT cycle.
// Backpressure: stall holds the CPU until its access completes; memory words advance only on mem_ack_i.
module cmu_param #(
   parameter int ADDR_BITS        = 32,
   parameter int INDEX_BITS       = 7,
   parameter int LINE_WORDS_WIDTH = 2,
   parameter int CNT_BITS         = 32,
   localparam int TAG_BITS        = ADDR_BITS - INDEX_BITS - LINE_WORDS_WIDTH - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_BITS-1:0]  addr_rw,
   input  logic                  en_r,
   input  logic                  en_w,
   input  logic [2:0]            u_b_h_w,
   input  logic [31:0]           data_w,
   output logic [31:0]           data_r,
   output logic                  stall,
   input  logic                  flush_req,
   input  logic [ADDR_BITS-1:0]  flush_addr,
   output logic                  flush_done,
   input  logic                  clr_cnt,
   output logic [CNT_BITS-1:0]   hit_cnt,
   output logic [CNT_BITS-1:0]   miss_cnt,
   output logic [ADDR_BITS-1:0]  cache_addr,
   output logic                  cache_load,
   output logic                  cache_edit,
   output logic                  cache_store,
   output logic                  cache_invalid,
   output logic [2:0]            cache_u_b_h_w,
   output logic [31:0]           cache_din,
   input  logic                  cache_hit,
   input  logic                  cache_valid,
   input  logic                  cache_dirty,
   input  logic [TAG_BITS-1:0]   cache_tag,
   input  logic [31:0]           cache_dout,
   output logic                  mem_cs_o,
   output logic                  mem_we_o,
   output logic [ADDR_BITS-1:0]  mem_addr_o,
   output logic [31:0]           mem_data_o,
   input  logic [31:0]           mem_data_i,
   input  logic                  mem_ack_i,
   output logic [2:0]            cmu_state
);

   localparam int LINE_LSB = LINE_WORDS_WIDTH + 2;
   localparam int IDX_MSB  = LINE_LSB + INDEX_BITS - 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BACK  = 3'd1,
      FILL  = 3'd2,
      WAIT  = 3'd3,
      INVAL = 3'd4
   } state_t;

   state_t                      state, next_state;
   logic [LINE_WORDS_WIDTH-1:0] word_count;
   logic [ADDR_BITS-1:0]        op_addr;
   logic                        op_flush;

   logic                        cpu_req;
   logic                        last_word;
   logic                        hit_inc, miss_inc, flush_take, done_raw;
   logic [ADDR_BITS-1:0]        word_addr;

   assign cpu_req   = en_r | en_w;
   assign last_word = &word_count;
   assign word_addr = {op_addr[ADDR_BITS-1:LINE_LSB], word_count, 2'b00};

   always_comb begin
      next_state    = state;
      cache_addr    = addr_rw;
      cache_load    = 1'b0;
      cache_edit    = 1'b0;
      cache_store   = 1'b0;
      cache_invalid = 1'b0;
      cache_u_b_h_w = u_b_h_w;
      cache_din     = data_w;
      mem_cs_o      = 1'b0;
      mem_we_o      = 1'b0;
      mem_addr_o    = '0;
      done_raw      = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      flush_take    = 1'b0;
      case (state)
         IDLE: begin
            cache_load = en_r & ~en_w;
            cache_edit = en_w;
            if (cpu_req) begin
               if (cache_hit) begin
                  hit_inc = 1'b1;
               end else begin
                  miss_inc   = 1'b1;
                  next_state = (cache_valid & cache_dirty) ? BACK : FILL;
               end
            end else if (flush_req) begin
               flush_take = 1'b1;
               cache_addr = flush_addr;
               if (cache_valid & cache_dirty) next_state = BACK;
               else if (cache_valid)          next_state = INVAL;
               else                           done_raw   = 1'b1;
            end
         end
         BACK: begin
            cache_addr    = word_addr;
            cache_load    = 1'b1;
            cache_u_b_h_w = 3'b010;
            mem_cs_o      = 1'b1;
            mem_we_o      = 1'b1;
            // Victim address is rebuilt from the stored tag, not the requesting address.
            mem_addr_o    = {cache_tag, op_addr[IDX_MSB:LINE_LSB], word_count, 2'b00};
            if (mem_ack_i && last_word) next_state = op_flush ? INVAL : FILL;
         end
         FILL: begin
            cache_addr    = word_addr;
            cache_store   = mem_ack_i;
            cache_din     = mem_data_i;
            cache_u_b_h_w = 3'b010;
            mem_cs_o      = 1'b1;
            mem_addr_o    = word_addr;
            if (mem_ack_i && last_word) next_state = WAIT;
         end
         WAIT: begin
            cache_addr = op_addr;
            cache_load = en_r & ~en_w;
            cache_edit = en_w;
            next_state = IDLE;
         end
         INVAL: begin
            cache_addr    = op_addr;
            cache_invalid = 1'b1;
            done_raw      = 1'b1;
            next_state    = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Reset must silence the flush pulse immediately, even from the IDLE invalid-line path.
   assign flush_done = done_raw & rst_n;
   assign stall      = cpu_req & (next_state != IDLE);
   assign data_r     = cache_dout;
   assign mem_data_o = cache_dout;
   assign cmu_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_count <= '0;
         op_addr    <= '0;
         op_flush   <= 1'b0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else begin
         state <= next_state;
         // Wraps to zero on the last word, leaving the counter ready for the next phase.
         if ((state == BACK || state == FILL) && mem_ack_i)
            word_count <= word_count + 1'b1;
         if (miss_inc) begin
            op_addr  <= addr_rw;
            op_flush <= 1'b0;
         end else if (flush_take) begin
            op_addr  <= flush_addr;
            op_flush <= 1'b1;
         end
         if (clr_cnt) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
         end else begin
            if (hit_inc && !(&hit_cnt))   hit_cnt  <= hit_cnt + 1'b1;
            if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmu_param.sv
// Directed bench for cmu_param: hits, clean/dirty misses, flushes, mid-transfer reset, counter saturation.
module tb_cmu_param;

   localparam int TAG_BITS = 21;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [31:0]         addr_rw, data_w, flush_addr, cache_dout, mem_data_i;
   logic                en_r, en_w, flush_req, clr_cnt, mem_ack_i;
   logic [2:0]          u_b_h_w;
   logic                cache_hit, cache_valid, cache_dirty;
   logic [TAG_BITS-1:0] cache_tag;

   logic [31:0] data_r, cache_addr, cache_din, mem_addr_o, mem_data_o, hit_cnt, miss_cnt;
   logic        stall, flush_done, cache_load, cache_edit, cache_store, cache_invalid;
   logic        mem_cs_o, mem_we_o;
   logic [2:0]  cache_u_b_h_w, cmu_state;

   logic [31:0] d4_data_r, d4_cache_addr, d4_cache_din, d4_mem_addr, d4_mem_data;
   logic [3:0]  d4_hit, d4_miss;
   logic        d4_stall, d4_flush_done, d4_load, d4_edit, d4_store, d4_inval, d4_cs, d4_we;
   logic [2:0]  d4_size, d4_state;

   int tests = 0;
   int fails = 0;
   int stall_cyc, stores;

   always #5 clk = ~clk;

   cmu_param dut (
      .clk(clk), .rst_n(rst_n), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
      .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
      .flush_req(flush_req), .flush_addr(flush_addr), .flush_done(flush_done),
      .clr_cnt(clr_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
      .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
      .cache_store(cache_store), .cache_invalid(cache_invalid),
      .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din), .cache_hit(cache_hit),
      .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
      .cache_dout(cache_dout), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .mem_ack_i(mem_ack_i), .cmu_state(cmu_state)
   );

   cmu_param #(.CNT_BITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
      .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(d4_data_r), .stall(d4_stall),
      .flush_req(flush_req), .flush_addr(flush_addr), .flush_done(d4_flush_done),
      .clr_cnt(clr_cnt), .hit_cnt(d4_hit), .miss_cnt(d4_miss),
      .cache_addr(d4_cache_addr), .cache_load(d4_load), .cache_edit(d4_edit),
      .cache_store(d4_store), .cache_invalid(d4_inval),
      .cache_u_b_h_w(d4_size), .cache_din(d4_cache_din), .cache_hit(cache_hit),
      .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
      .cache_dout(cache_dout), .mem_cs_o(d4_cs), .mem_we_o(d4_we),
      .mem_addr_o(d4_mem_addr), .mem_data_o(d4_mem_data), .mem_data_i(mem_data_i),
      .mem_ack_i(mem_ack_i), .cmu_state(d4_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; addr_rw = '0; en_r = 0; en_w = 0; u_b_h_w = 3'b010; data_w = '0;
      flush_req = 0; flush_addr = '0; clr_cnt = 0; cache_hit = 0; cache_valid = 0;
      cache_dirty = 0; cache_tag = '0; cache_dout = 32'h5A5A_0001; mem_data_i = '0; mem_ack_i = 0;
      #2;
      chk("rst_state", {29'd0, cmu_state}, 32'd0);
      chk("rst_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("rst_hitcnt", hit_cnt, 32'd0);
      chk("rst_done", {31'd0, flush_done}, 32'd0);
      cycle(); cycle();
      rst_n = 1'b1;

      // Read hit at 0x100
      addr_rw = 32'h100; en_r = 1; cache_hit = 1; cache_valid = 1;
      #2;
      chk("hit_stall", {31'd0, stall}, 32'd0);
      chk("hit_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("hit_load", {31'd0, cache_load}, 32'd1);
      chk("hit_caddr", cache_addr, 32'h100);
      chk("hit_dout", data_r, 32'h5A5A_0001);
      cycle();
      en_r = 0; cache_hit = 0;
      #2;
      chk("hit_cnt1", hit_cnt, 32'd1);
      chk("hit_state", {29'd0, cmu_state}, 32'd0);

      // Clean read miss at 0x1040, ack on third cycle of each word
      addr_rw = 32'h1040; en_r = 1; cache_hit = 0; cache_valid = 0; cache_dirty = 0;
      stall_cyc = 0; stores = 0;
      #2;
      chk("cm_idle_stall", {31'd0, stall}, 32'd1);
      stall_cyc += int'(stall);
      cycle();
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 3; k++) begin
            mem_ack_i = (k == 2);
            mem_data_i = 32'hD000 + w;
            #2;
            if (k == 0) begin
               chk("cm_fill_addr", mem_addr_o, 32'h1040 + 4 * w);
               chk("cm_fill_caddr", cache_addr, 32'h1040 + 4 * w);
               chk("cm_fill_we", {31'd0, mem_we_o}, 32'd0);
               chk("cm_fill_cs", {31'd0, mem_cs_o}, 32'd1);
            end
            if (k == 2) chk("cm_fill_din", cache_din, 32'hD000 + w);
            stall_cyc += int'(stall);
            stores += int'(cache_store);
            cycle();
         end
      end
      mem_ack_i = 0; cache_hit = 1; cache_valid = 1;
      #2;
      chk("cm_wait_state", {29'd0, cmu_state}, 32'd3);
      chk("cm_wait_stall", {31'd0, stall}, 32'd0);
      chk("cm_wait_caddr", cache_addr, 32'h1040);
      chk("cm_wait_load", {31'd0, cache_load}, 32'd1);
      chk("cm_wait_cs", {31'd0, mem_cs_o}, 32'd0);
      stall_cyc += int'(stall);
      cycle();
      en_r = 0; cache_hit = 0;
      #2;
      chk("cm_stall_cycles", stall_cyc, 32'd13);
      chk("cm_stores", stores, 32'd4);
      chk("cm_miss_cnt", miss_cnt, 32'd1);
      chk("cm_idle", {29'd0, cmu_state}, 32'd0);

      // Dirty write miss at 0x2000, victim tag 0x12; back with immediate acks, fill with one wait
      addr_rw = 32'h2000; en_w = 1; data_w = 32'hCAFE; cache_hit = 0; cache_valid = 1;
      cache_dirty = 1; cache_tag = 21'h12;
      #2;
      chk("dm_stall", {31'd0, stall}, 32'd1);
      cycle();
      for (int w = 0; w < 4; w++) begin
         mem_ack_i = 1;
         #2;
         chk("dm_back_state", {29'd0, cmu_state}, 32'd1);
         chk("dm_back_addr", mem_addr_o, 32'h9000 + 4 * w);
         chk("dm_back_we", {31'd0, mem_we_o}, 32'd1);
         chk("dm_back_caddr", cache_addr, 32'h2000 + 4 * w);
         cycle();
      end
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 2; k++) begin
            mem_ack_i = (k == 1);
            #2;
            if (k == 0) begin
               chk("dm_fill_state", {29'd0, cmu_state}, 32'd2);
               chk("dm_fill_addr", mem_addr_o, 32'h2000 + 4 * w);
            end
            cycle();
         end
      end
      mem_ack_i = 0; cache_hit = 1; cache_dirty = 0;
      #2;
      chk("dm_wait_state", {29'd0, cmu_state}, 32'd3);
      chk("dm_wait_edit", {31'd0, cache_edit}, 32'd1);
      chk("dm_wait_din", cache_din, 32'hCAFE);
      chk("dm_wait_stall", {31'd0, stall}, 32'd0);
      cycle();
      en_w = 0; cache_hit = 0;
      #2;
      chk("dm_miss_cnt", miss_cnt, 32'd2);

      // Flush of a dirty line at 0x3450, tag 0x7, no CPU traffic
      flush_req = 1; flush_addr = 32'h3450; cache_valid = 1; cache_dirty = 1; cache_tag = 21'h7;
      #2;
      chk("fl_caddr", cache_addr, 32'h3450);
      chk("fl_stall0", {31'd0, stall}, 32'd0);
      chk("fl_done0", {31'd0, flush_done}, 32'd0);
      cycle();
      flush_req = 0; flush_addr = '0;
      for (int w = 0; w < 4; w++) begin
         mem_ack_i = 1;
         #2;
         chk("fl_back_addr", mem_addr_o, 32'h3C50 + 4 * w);
         chk("fl_back_caddr", cache_addr, 32'h3450 + 4 * w);
         chk("fl_back_stall", {31'd0, stall}, 32'd0);
         cycle();
      end
      mem_ack_i = 0;
      #2;
      chk("fl_inval_state", {29'd0, cmu_state}, 32'd4);
      chk("fl_inval", {31'd0, cache_invalid}, 32'd1);
      chk("fl_done", {31'd0, flush_done}, 32'd1);
      chk("fl_inval_caddr", cache_addr, 32'h3450);
      cycle();
      #1;
      chk("fl_done_pulse", {31'd0, flush_done}, 32'd0);
      chk("fl_idle", {29'd0, cmu_state}, 32'd0);

      // Flush of an invalid line completes immediately
      flush_req = 1; flush_addr = 32'h500; cache_valid = 0; cache_dirty = 0;
      #2;
      chk("fi_done", {31'd0, flush_done}, 32'd1);
      cycle();
      flush_req = 0;
      #2;
      chk("fi_state", {29'd0, cmu_state}, 32'd0);

      // Reset during the third fill word
      addr_rw = 32'h4000; en_r = 1; cache_hit = 0; cache_valid = 0;
      cycle();
      for (int w = 0; w < 2; w++) begin
         mem_ack_i = 1;
         cycle();
      end
      mem_ack_i = 0;
      #2;
      chk("rm_word2_addr", mem_addr_o, 32'h4008);
      rst_n = 0;
      #1;
      chk("rm_cs", {31'd0, mem_cs_o}, 32'd0);
      chk("rm_state", {29'd0, cmu_state}, 32'd0);
      chk("rm_hit", hit_cnt, 32'd0);
      chk("rm_miss", miss_cnt, 32'd0);
      cycle();
      rst_n = 1;
      #2;
      chk("rm_restart_stall", {31'd0, stall}, 32'd1);
      cycle();
      chk("rm_restart_addr", mem_addr_o, 32'h4000);
      chk("rm_restart_caddr", cache_addr, 32'h4000);
      en_r = 0;
      rst_n = 0;
      #1;
      rst_n = 1;
      cycle();

      // Counter saturation on the 4-bit build, then clear beating a hit
      addr_rw = 32'h100; en_r = 1; cache_hit = 1; cache_valid = 1;
      repeat (20) cycle();
      chk("sat_hit4", {28'd0, d4_hit}, 32'd15);
      chk("sat_hit32", hit_cnt, 32'd20);
      clr_cnt = 1;
      cycle();
      clr_cnt = 0; en_r = 0; cache_hit = 0;
      #2;
      chk("clr_hit4", {28'd0, d4_hit}, 32'd0);
      chk("clr_hit32", hit_cnt, 32'd0);
      chk("clr_miss32", miss_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
